// File: rtl/dco_ctrl_if.sv
// Loop-filter to DCO controller interface.
// The loop filter (master) drives the step requests, the enable and the
// fractional dither width. The controller (slave) returns the integer DCO
// code, the dither bit and the status flags.
interface dco_ctrl_if #(
    parameter int NUM_DITHERING_BITS = 5,
    parameter int NUM_CODE_BITS      = 6
);
    logic                          enable;
    logic                          overflow;
    logic                          underflow;
    logic [NUM_DITHERING_BITS-1:0] ditherWidth;
    logic [NUM_CODE_BITS-1:0]      dcoCode;
    logic                          ditherOut;
    logic                          locked;
    logic                          railHit;

    modport master (
        output enable, overflow, underflow, ditherWidth,
        input  dcoCode, ditherOut, locked, railHit
    );

    modport slave (
        input  enable, overflow, underflow, ditherWidth,
        output dcoCode, ditherOut, locked, railHit
    );
endinterface

// File: rtl/dco_ctrl.sv
// DCO controller for the bang-bang PLL.
// Integrates overflow/underflow carries from the loop filter into a
// saturating integer DCO code, turns the fractional width into a 1-bit
// dither stream, and tracks lock from step activity.
// Optional build macro DCO_CTRL_SIGMA_DELTA_EN swaps the PWM dither
// comparator for a first-order sigma-delta modulator.
module dco_ctrl #(
    parameter int NUM_DITHERING_BITS = 5,
    parameter int NUM_CODE_BITS      = 6,
    parameter int CODE_RESET         = 32,
    parameter int CODE_MIN           = 0,
    parameter int CODE_MAX           = 63,
    parameter int LOCK_CYCLES        = 256,
    parameter int UNLOCK_STEPS       = 4
) (
    input logic       clock,
    input logic       reset,
    dco_ctrl_if.slave bus
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES);
    localparam int RUN_W  = $clog2(UNLOCK_STEPS + 1);

    localparam logic [NUM_CODE_BITS-1:0] CODE_RESET_C = NUM_CODE_BITS'(CODE_RESET);
    localparam logic [NUM_CODE_BITS-1:0] CODE_MIN_C   = NUM_CODE_BITS'(CODE_MIN);
    localparam logic [NUM_CODE_BITS-1:0] CODE_MAX_C   = NUM_CODE_BITS'(CODE_MAX);
    localparam logic [LOCK_W-1:0]        LOCK_LAST    = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [RUN_W-1:0]         RUN_LIMIT    = RUN_W'(UNLOCK_STEPS);

    typedef enum logic {
        ACQUIRE,
        LOCKED
    } lockState_t;

    lockState_t                    state_q, state_d;
    logic [NUM_CODE_BITS-1:0]      dcoCode_q, dcoCode_d;
    logic                          railHit_q, railHit_d;
    logic [NUM_DITHERING_BITS-1:0] phase_q, phase_d;
    logic [NUM_DITHERING_BITS-1:0] widthReg_q, widthReg_d;
    logic                          ditherOut_q, ditherOut_d;
    logic                          locked_q, locked_d;
    logic [LOCK_W-1:0]             lockCount_q, lockCount_d;
    logic [RUN_W-1:0]              runCount_q, runCount_d;
    logic                          runDir_q, runDir_d;
    logic [RUN_W-1:0]              runNext;

`ifdef DCO_CTRL_SIGMA_DELTA_EN
    logic [NUM_DITHERING_BITS-1:0] acc_q, acc_d;
    logic [NUM_DITHERING_BITS:0]   accSum;
`endif

    // Exactly one of overflow/underflow makes a step; both or neither cancel out.
    logic upReq, downReq, step, stepDir;
    assign upReq   = bus.overflow & ~bus.underflow;
    assign downReq = bus.underflow & ~bus.overflow;
    assign step    = bus.enable & (upReq | downReq);
    assign stepDir = upReq;

    // Saturating code update; a request that would cross a rail is flagged instead.
    always_comb begin
        dcoCode_d = dcoCode_q;
        railHit_d = 1'b0;
        if (bus.enable) begin
            if (upReq) begin
                if (dcoCode_q < CODE_MAX_C) dcoCode_d = dcoCode_q + 1'b1;
                else                        railHit_d = 1'b1;
            end else if (downReq) begin
                if (dcoCode_q > CODE_MIN_C) dcoCode_d = dcoCode_q - 1'b1;
                else                        railHit_d = 1'b1;
            end
        end
    end

    // Dither period counter; the width is only picked up on the wrap so every period is whole.
    always_comb begin
        phase_d     = phase_q;
        widthReg_d  = widthReg_q;
        ditherOut_d = ditherOut_q;
`ifdef DCO_CTRL_SIGMA_DELTA_EN
        acc_d       = acc_q;
        accSum      = {1'b0, acc_q} + {1'b0, widthReg_q};
`endif
        if (bus.enable) begin
            phase_d = phase_q + 1'b1;
            if (phase_q == '1) widthReg_d = bus.ditherWidth;
`ifdef DCO_CTRL_SIGMA_DELTA_EN
            acc_d       = accSum[NUM_DITHERING_BITS-1:0];
            ditherOut_d = accSum[NUM_DITHERING_BITS];
`else
            ditherOut_d = (phase_d < widthReg_d);
`endif
        end
    end

    // Lock detector: long quiet stretch locks, a run of same-direction steps unlocks.
    always_comb begin
        state_d     = state_q;
        locked_d    = locked_q;
        lockCount_d = lockCount_q;
        runCount_d  = runCount_q;
        runDir_d    = runDir_q;
        runNext     = '0;
        if (bus.enable) begin
            case (state_q)
                ACQUIRE: begin
                    if (step) begin
                        lockCount_d = '0;
                    end else if (lockCount_q == LOCK_LAST) begin
                        state_d    = LOCKED;
                        locked_d   = 1'b1;
                        runCount_d = '0;
                    end else begin
                        lockCount_d = lockCount_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (step) begin
                        if (stepDir == runDir_q) begin
                            runNext = runCount_q + 1'b1;
                        end else begin
                            runNext  = RUN_W'(1);
                            runDir_d = stepDir;
                        end
                        if (runNext == RUN_LIMIT) begin
                            state_d     = ACQUIRE;
                            locked_d    = 1'b0;
                            lockCount_d = '0;
                            runCount_d  = '0;
                        end else begin
                            runCount_d = runNext;
                        end
                    end
                end
                default: begin
                    state_d  = ACQUIRE;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // All state registers, with synchronous active-low reset taking priority over enable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ACQUIRE;
            dcoCode_q   <= CODE_RESET_C;
            railHit_q   <= 1'b0;
            phase_q     <= '0;
            widthReg_q  <= '0;
            ditherOut_q <= 1'b0;
            locked_q    <= 1'b0;
            lockCount_q <= '0;
            runCount_q  <= '0;
            runDir_q    <= 1'b0;
`ifdef DCO_CTRL_SIGMA_DELTA_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dcoCode_q   <= dcoCode_d;
            railHit_q   <= railHit_d;
            phase_q     <= phase_d;
            widthReg_q  <= widthReg_d;
            ditherOut_q <= ditherOut_d;
            locked_q    <= locked_d;
            lockCount_q <= lockCount_d;
            runCount_q  <= runCount_d;
            runDir_q    <= runDir_d;
`ifdef DCO_CTRL_SIGMA_DELTA_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign bus.dcoCode   = dcoCode_q;
    assign bus.ditherOut = ditherOut_q;
    assign bus.locked    = locked_q;
    assign bus.railHit   = railHit_q;

endmodule

// File: tb/tb_dco_ctrl.sv
// Directed bench for dco_ctrl: reset, code saturation, dither, lock
// detector, enable freeze and mid-lock reset.
module tb_dco_ctrl;

    logic clock = 1'b0;
    logic reset;
    int   assertCount = 0;
    int   failCount   = 0;

    dco_ctrl_if #(.NUM_DITHERING_BITS(5), .NUM_CODE_BITS(6)) bus ();

    dco_ctrl #(
        .NUM_DITHERING_BITS(5),
        .NUM_CODE_BITS(6),
        .CODE_RESET(32),
        .CODE_MIN(0),
        .CODE_MAX(63),
        .LOCK_CYCLES(256),
        .UNLOCK_STEPS(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    // 10 ns clock.
    always #5 clock = ~clock;

    // One rising edge, then settle 1 ns so outputs can be sampled and inputs changed.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.enable   = 1'b1;
        bus.overflow = 1'b1;
        reset        = 1'b0;
        tick();
        assertCount++;
        if (bus.dcoCode !== 6'd32) begin
            failCount++;
            $display("[TB] FAIL reset_code: got %0d expected 32", bus.dcoCode);
        end
        assertCount++;
        if (bus.ditherOut !== 1'b0 || bus.locked !== 1'b0 || bus.railHit !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_flags: got dither=%b locked=%b rail=%b expected 0 0 0",
                     bus.ditherOut, bus.locked, bus.railHit);
        end
        bus.overflow = 1'b0;
        reset        = 1'b1;
    endtask

    task automatic test_saturation();
        int expCode;
        logic expHit;
        doReset();
        bus.enable   = 1'b1;
        bus.overflow = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            expCode = (32 + i > 63) ? 63 : 32 + i;
            expHit  = (32 + i > 63);
            assertCount++;
            if (bus.dcoCode !== 6'(expCode) || bus.railHit !== expHit) begin
                failCount++;
                $display("[TB] FAIL sat_up cycle %0d: got code=%0d rail=%b expected code=%0d rail=%b",
                         i, bus.dcoCode, bus.railHit, expCode, expHit);
            end
        end
        bus.enable = 1'b0;
        tick();
        assertCount++;
        if (bus.dcoCode !== 6'd63 || bus.railHit !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sat_disable: got code=%0d rail=%b expected 63 0", bus.dcoCode, bus.railHit);
        end
        bus.enable    = 1'b1;
        bus.overflow  = 1'b0;
        bus.underflow = 1'b1;
        for (int i = 1; i <= 63; i++) begin
            tick();
            assertCount++;
            if (bus.dcoCode !== 6'(63 - i) || bus.railHit !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL sat_down cycle %0d: got code=%0d rail=%b expected code=%0d rail=0",
                         i, bus.dcoCode, bus.railHit, 63 - i);
            end
        end
        tick();
        assertCount++;
        if (bus.dcoCode !== 6'd0 || bus.railHit !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL sat_floor: got code=%0d rail=%b expected 0 1", bus.dcoCode, bus.railHit);
        end
        bus.overflow = 1'b1;
        tick();
        assertCount++;
        if (bus.dcoCode !== 6'd0 || bus.railHit !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sat_both: got code=%0d rail=%b expected 0 0", bus.dcoCode, bus.railHit);
        end
        bus.overflow  = 1'b0;
        bus.underflow = 1'b0;
    endtask

    task automatic test_dither();
        int ph;
        int mw = 0;
        int firstWidth;
`ifdef DCO_CTRL_SIGMA_DELTA_EN
        int highs = 0;
        int pairs = 0;
        int winW  = 0;
        logic prev = 1'b0;
        firstWidth = 8;
`else
        logic expOut;
        firstWidth = 5;
`endif
        doReset();
        bus.enable      = 1'b1;
        bus.ditherWidth = 5'(firstWidth);
        for (int k = 1; k <= 128; k++) begin
            if (k == 70) bus.ditherWidth = 5'd31;
            ph = k % 32;
`ifdef DCO_CTRL_SIGMA_DELTA_EN
            if (ph == 0) winW = mw;
`endif
            if (ph == 0) mw = int'(bus.ditherWidth);
            tick();
`ifdef DCO_CTRL_SIGMA_DELTA_EN
            if (bus.ditherOut === 1'b1) highs++;
            if (bus.ditherOut === 1'b1 && prev) pairs++;
            prev = bus.ditherOut;
            if (ph == 0) begin
                assertCount++;
                if (highs != winW) begin
                    failCount++;
                    $display("[TB] FAIL sd_duty period ending %0d: got %0d highs expected %0d", k, highs, winW);
                end
                if (winW <= 16) begin
                    assertCount++;
                    if (pairs != 0) begin
                        failCount++;
                        $display("[TB] FAIL sd_spread period ending %0d: got %0d adjacent highs expected 0", k, pairs);
                    end
                end
                highs = 0;
                pairs = 0;
            end
`else
            expOut = (ph < mw);
            assertCount++;
            if (bus.ditherOut !== expOut) begin
                failCount++;
                $display("[TB] FAIL pwm cycle %0d phase %0d: got %b expected %b", k, ph, bus.ditherOut, expOut);
            end
`endif
        end
        bus.ditherWidth = 5'd0;
    endtask

    task automatic test_lock();
        doReset();
        bus.enable = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k == 1 || k == 255) begin
                assertCount++;
                if (bus.locked !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL lock_early cycle %0d: got %b expected 0", k, bus.locked);
                end
            end
        end
        assertCount++;
        if (bus.locked !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL lock_rise: got %b expected 1", bus.locked);
        end
        for (int s = 0; s < 4; s++) begin
            bus.overflow  = (s % 2 == 0);
            bus.underflow = (s % 2 != 0);
            tick();
            assertCount++;
            if (bus.locked !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL lock_interleave step %0d: got %b expected 1", s, bus.locked);
            end
        end
        bus.overflow  = 1'b0;
        bus.underflow = 1'b0;
        tick();
        bus.overflow = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            tick();
            assertCount++;
            if (bus.locked !== (s < 4)) begin
                failCount++;
                $display("[TB] FAIL lock_run step %0d: got %b expected %b", s, bus.locked, (s < 4));
            end
        end
        bus.overflow = 1'b0;
        tick();
        assertCount++;
        if (bus.locked !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL lock_relock_early: got %b expected 0", bus.locked);
        end
    endtask

    task automatic test_enable_freeze();
        doReset();
        bus.enable      = 1'b1;
        bus.ditherWidth = 5'd5;
        for (int k = 1; k <= 34; k++) tick();
        assertCount++;
        if (bus.ditherOut !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL freeze_pre dither: got %b expected 1", bus.ditherOut);
        end
        bus.enable   = 1'b0;
        bus.overflow = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            assertCount++;
            if (bus.dcoCode !== 6'd32 || bus.ditherOut !== 1'b1 || bus.railHit !== 1'b0 || bus.locked !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL freeze cycle %0d: got code=%0d dither=%b rail=%b locked=%b expected 32 1 0 0",
                         k, bus.dcoCode, bus.ditherOut, bus.railHit, bus.locked);
            end
        end
        bus.overflow = 1'b0;
        bus.enable   = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            assertCount++;
            if (bus.ditherOut !== (k < 3)) begin
                failCount++;
                $display("[TB] FAIL freeze_resume dither cycle %0d: got %b expected %b", k, bus.ditherOut, (k < 3));
            end
        end
        for (int k = 1; k <= 219; k++) begin
            tick();
            if (k >= 218) begin
                assertCount++;
                if (bus.locked !== (k == 219)) begin
                    failCount++;
                    $display("[TB] FAIL freeze_lockcount cycle %0d: got %b expected %b", k, bus.locked, (k == 219));
                end
            end
        end
    endtask

    task automatic test_reset_mid_lock();
        bus.overflow = 1'b1;
        tick();
        assertCount++;
        if (bus.dcoCode !== 6'd33 || bus.locked !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midlock_pre: got code=%0d locked=%b expected 33 1", bus.dcoCode, bus.locked);
        end
        reset = 1'b0;
        tick();
        assertCount++;
        if (bus.dcoCode !== 6'd32 || bus.locked !== 1'b0 || bus.ditherOut !== 1'b0 || bus.railHit !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midlock_reset: got code=%0d locked=%b dither=%b rail=%b expected 32 0 0 0",
                     bus.dcoCode, bus.locked, bus.ditherOut, bus.railHit);
        end
        reset        = 1'b1;
        bus.overflow = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
`ifndef DCO_CTRL_SIGMA_DELTA_EN
            assertCount++;
            if (bus.ditherOut !== (k == 32)) begin
                failCount++;
                $display("[TB] FAIL midlock_first_period cycle %0d: got %b expected %b", k, bus.ditherOut, (k == 32));
            end
`else
            assertCount++;
            if (bus.ditherOut !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL midlock_first_period cycle %0d: got %b expected 0", k, bus.ditherOut);
            end
`endif
        end
    endtask

    initial begin
        reset           = 1'b0;
        bus.enable      = 1'b0;
        bus.overflow    = 1'b0;
        bus.underflow   = 1'b0;
        bus.ditherWidth = 5'd0;
        test_reset();
        test_saturation();
        test_dither();
        test_lock();
        test_enable_freeze();
        test_reset_mid_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dco_ctrl.md
Name: dco_ctrl

Overview:
- Consumer end of the loop-filter output interface in the bang-bang PLL.
- Turns `overflow`/`underflow` carry pulses into a saturating integer DCO code.
- Turns the fractional `ditherWidth` word into a 1-bit dither stream for the DCO fine cell.
- Adds a step-activity lock detector; sits between the loop filter and the DCO bank.

Parameters:
- NUM_DITHERING_BITS, 5, width of `ditherWidth`; dither period is 2^NUM_DITHERING_BITS cycles.
- NUM_CODE_BITS, 6, width of the integer DCO code.
- CODE_RESET, 32, `dcoCode` value after reset.
- CODE_MIN, 0, lower saturation bound (inclusive).
- CODE_MAX, 63, upper saturation bound (inclusive); CODE_MIN <= CODE_RESET <= CODE_MAX.
- LOCK_CYCLES, 256, step-free enabled cycles required to declare lock (>= 2).
- UNLOCK_STEPS, 4, consecutive same-direction steps that drop lock (>= 2).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low; one clock, reset is synchronous and active-low.
- enable  input  1  advance all state when 1; hold all state when 0.
- overflow  input  1  increment request (1-cycle pulse per step).
- underflow  input  1  decrement request.
- ditherWidth  input  NUM_DITHERING_BITS  dither high time, in cycles per period.
- dcoCode  output  NUM_CODE_BITS  registered integer DCO code.
- ditherOut  output  1  registered dither bit.
- locked  output  1  registered lock flag.
- railHit  output  1  registered; 1 for one cycle when a step request is clipped by saturation.

Behaviour:
- Reset (reset==0 at a rising edge):
  - dcoCode=CODE_RESET; ditherOut=0; locked=0; railHit=0.
  - phase=0; widthReg=0; lockCount=0; runCount=0; runDir=0; state=ACQUIRE.
  - Reset has priority over enable.
- enable==0: every register holds, and railHit is forced to 0 on the next edge.
- Code update: 1-cycle latency, decided on the edge where the inputs are sampled.
  - overflow&!underflow: dcoCode+1 if below CODE_MAX; otherwise hold and railHit=1.
  - underflow&!overflow: dcoCode-1 if above CODE_MIN; otherwise hold and railHit=1.
  - Both or neither asserted: hold, no step, railHit=0.
- A "step" is any accepted or clipped request with exactly one of overflow/underflow set. Direction: up=1, down=0.
- Dither (PWM):
  - `phase` is a NUM_DITHERING_BITS counter that wraps max→0.
  - On the wrap edge, widthReg<=ditherWidth, so a new width takes effect at the start of the next full period.
  - ditherOut is registered so it is high exactly while phase < widthReg.
  - Width 0 → constant 0. Width 2^N-1 → high 2^N-1 of every 2^N cycles.
  - The first period after reset uses width 0.
- Lock FSM: states ACQUIRE, LOCKED. Updates only on enabled cycles.
  - ACQUIRE:
    - A step clears lockCount; otherwise lockCount increments, saturating.
    - When lockCount reaches LOCK_CYCLES-1 on a step-free cycle, go to LOCKED and set locked=1 on that edge.
  - LOCKED:
    - A step in the same direction as runDir increments runCount.
    - A step in the opposite direction sets runCount=1 and runDir=dir.
    - Step-free cycles do not touch runCount.
    - When runCount would reach UNLOCK_STEPS: go to ACQUIRE, locked=0, lockCount=0, runCount=0.
  - Entering LOCKED clears runCount.
  - A clipped step counts as a step.
- Reset asserted mid-period or mid-count aborts everything to the reset values above.

Optional Feature:
- Macro: DCO_CTRL_SIGMA_DELTA_EN.
- Defined: the PWM comparator is replaced by a first-order sigma-delta.
  - acc (NUM_DITHERING_BITS bits, reset 0) does acc<=acc+widthReg every enabled cycle.
  - ditherOut<=carry-out of that sum.
  - widthReg still reloads only on the phase wrap edge.
  - Average duty equals widthReg/2^N, with maximum spreading of the high bits.
- Undefined: PWM behaviour as above; no acc register exists.

Test Plan:
- Reset, then hold overflow=1 for 40 enabled cycles → dcoCode rises 32→63 over 31 cycles. railHit=1 on each of the remaining 9 cycles; dcoCode stays 63.
- dcoCode=0, then underflow=1 → dcoCode stays 0 and railHit=1. Then overflow=underflow=1 → no change and railHit=0.
- ditherWidth=5 held (N=5) → from the second period on, ditherOut=1 for phases 0–4 and 0 for phases 5–31. Change to 31 mid-period → the new duty appears only after the next wrap.
- No steps for 256 enabled cycles → locked rises on cycle 256. Then 4 consecutive overflow steps → locked=0 after the 4th. An interleaved pattern up, down, up, down keeps locked=1.
- enable=0 for 10 cycles mid-period while overflow=1 → dcoCode, phase, ditherOut and lockCount all frozen, railHit=0. Assert reset mid-lock → all outputs return to reset values on the next edge.
- With DCO_CTRL_SIGMA_DELTA_EN and ditherWidth=8 → ditherOut is high exactly 8 of each 32 cycles, never 2 consecutive highs.
